gpio_irq_bank: RTL



---
 rtl/gpio_irq_bank.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/gpio_irq_bank.sv
// gpio_irq_bank: NUM_IO-pin GPIO with synchronised inputs and per-pin IRQs.
// Optional input debounce filter enabled by defining GPIO_DEBOUNCE_EN.
module gpio_irq_bank #(
  parameter int NUM_IO          = 16,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       data_i,
  input  logic [3:0]        sel_i,
  input  logic              we_i,
  output logic [31:0]       data_o,
  input  logic [NUM_IO-1:0] io_pin_i,
  output logic [NUM_IO-1:0] io_oe_o,
  output logic [NUM_IO-1:0] io_out_o,
  output logic              irq_o
);

  localparam logic [2:0] OFF_DIR  = 3'd0;
  localparam logic [2:0] OFF_DOUT = 3'd1;
  localparam logic [2:0] OFF_DIN  = 3'd2;
  localparam logic [2:0] OFF_EN   = 3'd3;
  localparam logic [2:0] OFF_TYPE = 3'd4;
  localparam logic [2:0] OFF_POL  = 3'd5;
  localparam logic [2:0] OFF_PEND = 3'd6;
  localparam logic [2:0] OFF_TGL  = 3'd7;

  typedef logic [NUM_IO-1:0] vec_t;

  logic [2:0]  off;
  logic [31:0] bmask;
  vec_t        wmask;
  vec_t        wdata;

  vec_t dir_q,  dir_d;
  vec_t dout_q, dout_d;
  vec_t en_q,   en_d;
  vec_t type_q, type_d;
  vec_t pol_q,  pol_d;
  vec_t pend_q, pend_d;
  vec_t prev_q;
  vec_t sync_q [SYNC_STAGES];

  vec_t sync_in;
  vec_t din_val;
  vec_t evt;
  vec_t clr;

  logic [31:0] rdata;
  logic [31:0] data_q;
  logic        irq_q;

  logic unused_ok;

  assign off   = addr_i[4:2];
  assign bmask = {{8{sel_i[3]}}, {8{sel_i[2]}},
                  {8{sel_i[1]}}, {8{sel_i[0]}}};
  assign wmask = bmask[NUM_IO-1:0];
  assign wdata = data_i[NUM_IO-1:0];

  assign unused_ok = ^{addr_i[31:5], addr_i[1:0],
                       data_i, bmask};

  function automatic logic [31:0] ext(input vec_t v);
    logic [31:0] r;
    r = '0;
    r[NUM_IO-1:0] = v;
    return r;
  endfunction

  function automatic vec_t merge(input vec_t q,
                                 input vec_t d,
                                 input vec_t m);
    return (q & ~m) | (d & m);
  endfunction

  // Input synchroniser chain; the last stage is the clean pin value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++)
        sync_q[s] <= '0;
    end else begin
      sync_q[0] <= io_pin_i;
      for (int s = 1; s < SYNC_STAGES; s++)
        sync_q[s] <= sync_q[s-1];
    end
  end

  assign sync_in = sync_q[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
  localparam logic [15:0] DEB_LAST =
    16'(DEBOUNCE_CYCLES - 1);

  vec_t        deb_q;
  logic [15:0] cnt_q [NUM_IO];

  // Debounce: adopt sync_in only after it differs for DEB cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_q <= '0;
      for (int i = 0; i < NUM_IO; i++)
        cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_IO; i++) begin
        if (sync_in[i] == deb_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == DEB_LAST) begin
          deb_q[i] <= sync_in[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 16'd1;
        end
      end
    end
  end

  assign din_val = deb_q;
`else
  assign din_val = sync_in;
`endif

  // Per-pin event: level match, or the selected edge vs prev_in.
  always_comb begin
    evt = (~type_q & ~(din_val ^ pol_q))
        | ( type_q &  pol_q &  din_val & ~prev_q)
        | ( type_q & ~pol_q & ~din_val &  prev_q);
  end

  // W1C mask for the pending register.
  always_comb begin
    clr = '0;
    if (we_i && off == OFF_PEND)
      clr = wdata & wmask;
  end

  // Register write decode with byte enables.
  always_comb begin
    dir_d  = dir_q;
    dout_d = dout_q;
    en_d   = en_q;
    type_d = type_q;
    pol_d  = pol_q;
    if (we_i) begin
      unique case (off)
        OFF_DIR:  dir_d  = merge(dir_q, wdata, wmask);
        OFF_DOUT: dout_d = merge(dout_q, wdata, wmask);
        OFF_EN:   en_d   = merge(en_q, wdata, wmask);
        OFF_TYPE: type_d = merge(type_q, wdata, wmask);
        OFF_POL:  pol_d  = merge(pol_q, wdata, wmask);
        OFF_TGL:  dout_d = dout_q ^ (wdata & wmask);
        OFF_DIN,
        OFF_PEND: ;
        default:  ;
      endcase
    end
  end

  // Set has priority over a same-cycle clear.
  always_comb begin
    pend_d = (pend_q & ~clr) | evt;
  end

  // Read mux, sampled into data_o on the next edge.
  always_comb begin
    rdata = '0;
    unique case (off)
      OFF_DIR:  rdata = ext(dir_q);
      OFF_DOUT: rdata = ext(dout_q);
      OFF_DIN:  rdata = ext(din_val);
      OFF_EN:   rdata = ext(en_q);
      OFF_TYPE: rdata = ext(type_q);
      OFF_POL:  rdata = ext(pol_q);
      OFF_PEND: rdata = ext(pend_q);
      OFF_TGL:  rdata = '0;
      default:  rdata = '0;
    endcase
  end

  // Control and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir_q  <= '0;
      dout_q <= '0;
      en_q   <= '0;
      type_q <= '0;
      pol_q  <= '0;
      pend_q <= '0;
    end else begin
      dir_q  <= dir_d;
      dout_q <= dout_d;
      en_q   <= en_d;
      type_q <= type_d;
      pol_q  <= pol_d;
      pend_q <= pend_d;
    end
  end

  // prev_in always tracks so mode changes cause no false edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      prev_q <= '0;
    else
      prev_q <= din_val;
  end

  // Registered read data and combined interrupt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      data_q <= rdata;
      irq_q  <= |(pend_q & en_q);
    end
  end

  assign data_o   = data_q;
  assign irq_o    = irq_q;
  assign io_oe_o  = dir_q;
  assign io_out_o = dout_q;

endmodule
